// File: rtl/led7_ring_seq.sv
// led7_ring_seq - position sequencer for the 12-position 7-segment ring
// animation decoder. Produces a timed index stream 0..11 with run / pause /
// single-step control, direction and speed selection, and lap counting that
// ends in a one-cycle `done` pulse when a non-zero lap target is reached.
//
// Parameters:
//   TICK_DIV  base clock cycles per index advance at speed 0
//   DIV_W     prescaler width (must hold TICK_DIV-1)
//   LAP_W     width of lap target / lap counter
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   pulse: start from IDLE/DONE, resume from PAUSE
//   stop     in   pulse: RUN->PAUSE, PAUSE/DONE->IDLE (wins over start)
//   step     in   level: rising edge advances one position in PAUSE
//   dir      in   0 ascending, 1 descending
//   speed    in   advance period = TICK_DIV >> speed cycles
//   laps     in   lap target, 0 = run forever
//   idx      out  ring position 0..11
//   running  out  high only in RUN
//   lap_cnt  out  completed laps since last start
//   done     out  one-cycle pulse when the lap target is reached
//
// Build option:
//   LED7_RING_BOUNCE_EN  ping-pong mode: direction reverses at the ends of
//                        the ring, `dir` only seeds it on a fresh start, and
//                        a lap is counted on each arrival at index 0.
module led7_ring_seq #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned DIV_W    = 25,
  parameter int unsigned LAP_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
  input  logic [1:0]       speed,
  input  logic [LAP_W-1:0] laps,
  output logic [3:0]       idx,
  output logic             running,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] TICK_V  = DIV_W'(TICK_DIV);
  localparam logic [3:0]       IDX_MAX = 4'd11;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             step_prev_q, step_prev_d;

  logic [DIV_W-1:0] period, thresh;
  logic [3:0]       adv_idx;
  logic             adv_wrap;
  logic             do_adv, restart;
  logic [LAP_W-1:0] lap_inc;
  logic             lap_hit;

  // Advance threshold; a period that shifts down to zero is treated as one
  // cycle so the subtraction never underflows.
  always_comb begin
    period = TICK_V >> speed;
    thresh = (period == '0) ? '0 : period - DIV_W'(1);
  end

`ifdef LED7_RING_BOUNCE_EN
  logic dir_q, dir_d, adv_dir;

  // Ping-pong: reverse at the ends; reaching 0 (from 1) completes a lap.
  always_comb begin
    adv_idx  = '0;
    adv_wrap = 1'b0;
    adv_dir  = dir_q;
    if (idx_q > IDX_MAX) begin
      adv_idx = '0;
    end else if (!dir_q) begin
      if (idx_q == IDX_MAX) begin
        adv_idx = IDX_MAX - 4'd1;
        adv_dir = 1'b1;
      end else begin
        adv_idx = idx_q + 4'd1;
      end
    end else begin
      if (idx_q == '0) begin
        adv_idx = 4'd1;
        adv_dir = 1'b0;
      end else begin
        adv_idx  = idx_q - 4'd1;
        adv_wrap = (idx_q == 4'd1);
      end
    end
  end

  always_comb begin
    dir_d = dir_q;
    if (restart) begin
      dir_d = dir;
    end else if (do_adv) begin
      dir_d = adv_dir;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  // Wrap mode: the end-to-end jump in the current direction completes a lap.
  always_comb begin
    adv_idx  = '0;
    adv_wrap = 1'b0;
    if (idx_q > IDX_MAX) begin
      adv_idx = '0;
    end else if (!dir) begin
      if (idx_q == IDX_MAX) begin
        adv_idx  = '0;
        adv_wrap = 1'b1;
      end else begin
        adv_idx = idx_q + 4'd1;
      end
    end else begin
      if (idx_q == '0) begin
        adv_idx  = IDX_MAX;
        adv_wrap = 1'b1;
      end else begin
        adv_idx = idx_q - 4'd1;
      end
    end
  end
`endif

  always_comb begin
    lap_inc = (&lap_q) ? lap_q : lap_q + LAP_W'(1);
    lap_hit = (laps != '0) && (lap_inc == laps);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lap_d       = lap_q;
    presc_d     = presc_q;
    done_d      = 1'b0;
    step_prev_d = step;
    do_adv      = 1'b0;
    restart     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          restart = 1'b1;
        end
      end
      S_RUN: begin
        // A stop without an advance freezes the prescaler where it is so the
        // resumed period is completed rather than restarted.
        if (presc_q >= thresh) begin
          presc_d = '0;
          do_adv  = 1'b1;
        end else if (!stop) begin
          presc_d = presc_q + DIV_W'(1);
        end
        if (stop) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (start) begin
          state_d = S_RUN;
        end else if (step && !step_prev_q) begin
          do_adv = 1'b1;
        end
      end
      S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (start) begin
          restart = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    if (restart) begin
      state_d = S_RUN;
      idx_d   = '0;
      lap_d   = '0;
      presc_d = '0;
    end

    // Applied after the state decision: an advance coinciding with stop still
    // lands, and reaching the lap target overrides the PAUSE/RUN choice.
    if (do_adv) begin
      idx_d = adv_idx;
      if (adv_wrap) begin
        lap_d = lap_inc;
        if (lap_hit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
    end

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      lap_q       <= '0;
      presc_q     <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lap_q       <= lap_d;
      presc_q     <= presc_d;
      running_q   <= running_d;
      done_q      <= done_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign idx     = idx_q;
  assign running = running_q;
  assign lap_cnt = lap_q;
  assign done    = done_q;

endmodule

// File: tb/tb_led7_ring_seq.sv
// Testbench for led7_ring_seq with TICK_DIV=8. A table of records gives the
// inputs to hold for a number of clock edges and the outputs expected after
// the last edge; the driver pushes those expectations into a scoreboard queue
// and a negedge monitor pops and compares them. Reset is exercised by hand
// at the end, including an asynchronous assertion between clock edges.
module tb_led7_ring_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, step, dir;
  logic [1:0] speed;
  logic [3:0] laps;
  logic [3:0] idx;
  logic       running;
  logic [3:0] lap_cnt;
  logic       done;

  led7_ring_seq #(
    .TICK_DIV (8),
    .DIV_W    (4),
    .LAP_W    (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .dir     (dir),
    .speed   (speed),
    .laps    (laps),
    .idx     (idx),
    .running (running),
    .lap_cnt (lap_cnt),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, stop, step, dir;
    logic [1:0]  speed;
    logic [3:0]  laps;
    int unsigned cyc;
    logic [3:0]  e_idx;
    logic        e_run;
    logic [3:0]  e_lap;
    logic        e_done;
  } vec_t;

  typedef struct {
    int unsigned due;
    int unsigned id;
    logic [3:0]  idx;
    logic        run;
    logic [3:0]  lap;
    logic        done;
  } exp_t;

  vec_t        vt[$];
  exp_t        sbq[$];
  exp_t        e;
  int unsigned cyc_cnt = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        finish_req = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic vec_t mk(input logic st, input logic sp, input logic stp,
                              input logic d, input logic [1:0] spd,
                              input logic [3:0] lp, input int unsigned c,
                              input logic [3:0] ei, input logic er,
                              input logic [3:0] el, input logic ed);
    vec_t v;
    v.start = st; v.stop = sp; v.step = stp; v.dir = d; v.speed = spd;
    v.laps = lp; v.cyc = c; v.e_idx = ei; v.e_run = er; v.e_lap = el;
    v.e_done = ed;
    return v;
  endfunction

  task automatic cmp(input string nm, input int unsigned id,
                     input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL vec%0d %s: got %0d, want %0d", id, nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc_cnt) begin
      e = sbq.pop_front();
      if (e.due != cyc_cnt) begin
        n_cmp++;
        n_err++;
        $display("FAIL vec%0d missed: due %0d, now %0d", e.id, e.due, cyc_cnt);
      end else begin
        cmp("idx",     e.id, int'(idx),     int'(e.idx));
        cmp("running", e.id, int'(running), int'(e.run));
        cmp("lap_cnt", e.id, int'(lap_cnt), int'(e.lap));
        cmp("done",    e.id, int'(done),    int'(e.done));
      end
    end
    if (finish_req) begin
      if (sbq.size() != 0) begin
        n_err += sbq.size();
        $display("FAIL leftover: got %0d pending, want 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  task automatic expect_now(input int unsigned id, input logic [3:0] ei,
                            input logic er, input logic [3:0] el,
                            input logic ed);
    exp_t x;
    x.due = cyc_cnt; x.id = id; x.idx = ei; x.run = er; x.lap = el;
    x.done = ed;
    sbq.push_back(x);
  endtask

  task automatic run_vec(input vec_t v, input int unsigned id);
    start = v.start; stop = v.stop; step = v.step; dir = v.dir;
    speed = v.speed; laps = v.laps;
    for (int unsigned i = 0; i < v.cyc; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
    end
    expect_now(id, v.e_idx, v.e_run, v.e_lap, v.e_done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        st sp stp d spd laps cyc   idx run lap done
`ifdef LED7_RING_BOUNCE_EN
    vt.push_back(mk(1, 0, 0, 0, 3, 0,  1,   0, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 3, 0, 11,  11, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 3, 0,  1,  10, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 3, 0, 10,   0, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 3, 0,  1,   1, 1, 1, 0));
    vt.push_back(mk(0, 1, 0, 1, 3, 0,  1,   2, 0, 1, 0));
    vt.push_back(mk(0, 0, 1, 1, 3, 0,  2,   3, 0, 1, 0));
    vt.push_back(mk(0, 1, 0, 1, 3, 0,  1,   0, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 3, 1,  1,   0, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 3, 1,  1,   1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 3, 1, 10,  11, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 3, 1, 11,   0, 0, 1, 1));
`else
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  1,   0, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  7,   0, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1,   1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 80,  11, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  8,   0, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0,  8,  11, 1, 2, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  5,  11, 1, 2, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 0,  1,  11, 0, 2, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 10,  11, 0, 2, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  1,  11, 1, 2, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  2,  11, 1, 2, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1,   0, 1, 3, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 0,  1,   0, 0, 3, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 0,  4,   1, 0, 3, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  2,   1, 0, 3, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 0,  3,   2, 0, 3, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  2,   2, 0, 3, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 0,  5,   3, 0, 3, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 0,  1,   0, 0, 3, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 0,  2,   0, 0, 3, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  3,   0, 0, 3, 0));
    vt.push_back(mk(1, 0, 0, 1, 2, 2,  1,   0, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 2, 2,  1,   0, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 2, 2,  1,  11, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 2, 2, 22,   0, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 2, 2,  1,   0, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 2, 2,  1,  11, 0, 2, 1));
    vt.push_back(mk(0, 0, 0, 1, 2, 2,  1,  11, 0, 2, 0));
    vt.push_back(mk(0, 0, 0, 1, 2, 2,  5,  11, 0, 2, 0));
    vt.push_back(mk(1, 0, 0, 0, 3, 1,  1,   0, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 3, 1, 11,  11, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 3, 1,  1,   0, 0, 1, 1));
    vt.push_back(mk(0, 1, 0, 0, 3, 1,  1,   0, 0, 1, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  1,   0, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  7,   0, 1, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 0,  1,   1, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  1,   1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  5,   1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 2, 0,  1,   2, 1, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 2, 0,  1,   2, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 2, 0,  1,   0, 0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 3, 0,  1,   0, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 3, 0, 192,  0, 1, 15, 0));
`endif

    start = 1'b0; stop = 1'b0; step = 1'b0; dir = 1'b0;
    speed = 2'd0; laps = 4'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_now(900, 4'd0, 1'b0, 4'd0, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int unsigned i = 0; i < vt.size(); i++) begin
      run_vec(vt[i], i);
    end

    // Asynchronous reset in the middle of a run: outputs clear before the
    // next clock edge.
    start = 1'b1; stop = 1'b0; step = 1'b0; dir = 1'b0;
    speed = 2'd0; laps = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    expect_now(901, 4'd0, 1'b0, 4'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_now(902, 4'd0, 1'b0, 4'd0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expect_now(903, 4'd0, 1'b1, 4'd0, 1'b0);
    @(posedge clk); #1;
    finish_req = 1'b1;
  end

endmodule

// File: doc/led7_ring_seq.md
Name: led7_ring_seq

Overview:
- Sequencer that drives the 4-bit position index of the 12-position 7-segment ring animation decoder.
- Generates a timed index stream 0..11 with run/pause/single-step, direction and speed control, and lap counting with a terminal `done` pulse.
- Sits between board buttons/switches and the combinational segment decoder; its `idx` output connects directly to the decoder's `idx` input.

Parameters:
- TICK_DIV, 25000000, base clock cycles per index advance at speed 0 (bench uses 8).
- DIV_W, 25, prescaler width; must hold TICK_DIV-1.
- LAP_W, 4, width of lap target and lap counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; start from IDLE/DONE, resume from PAUSE.
- stop  in  1  single-cycle pulse; RUN->PAUSE, PAUSE/DONE->IDLE.
- step  in  1  level; rising edge advances one position while in PAUSE.
- dir  in  1  0 = ascending index, 1 = descending index.
- speed  in  2  advance period = TICK_DIV >> speed cycles.
- laps  in  LAP_W  lap target; 0 = run forever.
- idx  out  4  ring position, always 0..11.
- running  out  1  high only in RUN.
- lap_cnt  out  LAP_W  completed laps since last start.
- done  out  1  one-cycle pulse when lap target is reached.

Behaviour:
- Reset (async, rst_n=0): state IDLE; idx=0; running=0; lap_cnt=0; done=0; prescaler=0; step edge register=0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- IDLE:
  - start -> RUN; idx=0, lap_cnt=0, prescaler=0.
  - step ignored.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler >= (TICK_DIV>>speed)-1: prescaler=0 and idx advances. The >= compare makes a mid-count speed change safe.
  - stop -> PAUSE; prescaler holds its value.
  - step ignored.
- PAUSE:
  - start -> RUN; prescaler resumes from its held value.
  - step rising edge (step=1, previous=0) -> one advance; stays in PAUSE unless the lap target is hit.
  - stop -> IDLE; idx=0.
- DONE:
  - running=0; idx holds.
  - start -> RUN with restart semantics (as from IDLE).
  - stop -> IDLE; idx=0.
- Advance rule:
  - dir=0: idx+1, with 11->0 wrap.
  - dir=1: idx-1, with 0->11 wrap.
  - dir is sampled at each advance.
- Lap accounting:
  - Each wrap increments lap_cnt. lap_cnt saturates at all-ones when laps=0.
  - If laps!=0 and the new lap_cnt==laps: go to DONE, done=1 for exactly that cycle, idx = wrapped value.
- Simultaneous events:
  - start and stop in the same cycle: stop wins.
  - Advance and stop in the same cycle in RUN: advance is applied, then PAUSE.
- Latency:
  - start sampled at edge k -> running=1 after edge k.
  - First advance occurs (TICK_DIV>>speed) cycles later.
- Reset mid-operation: immediate return to reset values, no done pulse.
- idx never leaves 0..11; any illegal value reachable by fault recovers to 0 on the next advance.

Optional Feature:
- Macro: LED7_RING_BOUNCE_EN.
- Defined (ping-pong mode):
  - At idx=11 while ascending, direction flips to descending; at idx=0 while descending, it flips to ascending.
  - dir only sets the initial direction on start from IDLE/DONE.
  - A lap is counted on each arrival at idx=0.
- Undefined: wrap mode exactly as above; no internal direction register.

Test Plan (TICK_DIV=8):
- Reset, start, speed=0, dir=0, laps=0 -> idx advances 0,1,...,11,0 every 8 cycles; lap_cnt=1 after the 11->0 wrap; running=1.
- dir=1, speed=2, laps=2, start -> idx 0,11,10,... every 2 cycles; after the second 0->11 wrap, done=1 for one cycle, state DONE, running=0, idx=11.
- In RUN, pulse stop at prescaler=5, then hold 10 cycles, then start -> idx frozen while paused; next advance occurs 3 cycles after start.
- In PAUSE, toggle step 3 times with step held high several cycles each -> idx advances exactly 3 positions.
- start and stop pulsed in the same cycle from IDLE -> stays IDLE.
- In RUN, drive rst_n low mid-count -> all outputs 0 immediately.
- With LED7_RING_BOUNCE_EN defined -> sequence 0..11,10..0,1 with lap_cnt=1 on return to 0.
